// File: rtl/pht_update_scheduler_if.sv
// Update-request bus into the PHT write scheduler: REQ_NUM ports sampled together,
// with a single ready covering all of them.
interface pht_update_scheduler_if #(
    parameter int REQ_NUM = 2,
    parameter int IDX_W   = 10,
    parameter int DATA_W  = 8
);
    logic [REQ_NUM-1:0]             reqValid;
    logic [REQ_NUM-1:0][IDX_W-1:0]  reqIdx;
    logic [REQ_NUM-1:0][DATA_W-1:0] reqData;
    logic                           reqReady;

    modport master (output reqValid, reqIdx, reqData, input reqReady);
    modport slave  (input reqValid, reqIdx, reqData, output reqReady);
endinterface

// File: rtl/pht_update_scheduler.sv
// PHT write scheduler: clears the table with an init sweep, then serialises
// multi-port update requests through a small in-order FIFO, one write per cycle.
module pht_req_lane #(
    parameter int LANE    = 0,
    parameter int REQ_NUM = 2,
    parameter int IDX_W   = 10
) (
    input  logic [REQ_NUM-1:0]            valid,
    input  logic [REQ_NUM-1:0][IDX_W-1:0] idx,
    output logic                          keep
);
    // A younger port hitting the same index supersedes this one.
    always_comb begin
        keep = valid[LANE];
        for (int j = LANE + 1; j < REQ_NUM; j++)
            if (valid[j] && idx[j] == idx[LANE]) keep = 1'b0;
    end
endmodule

module pht_update_scheduler #(
    parameter int              ENTRY_NUM   = 1024,
    parameter int              IDX_W       = 10,
    parameter int              DATA_W      = 8,
    parameter int              REQ_NUM     = 2,
    parameter int              QUEUE_DEPTH = 4,
    parameter logic [DATA_W-1:0] INIT_VALUE = 8'h22
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 initStart,
    pht_update_scheduler_if.slave req,
    output logic                 we,
    output logic [IDX_W-1:0]     wa,
    output logic [DATA_W-1:0]    wv,
    output logic                 busy,
    output logic [7:0]           dropCount
);
    localparam int SWP_W = IDX_W + 1;
    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int OCC_W = $clog2(QUEUE_DEPTH + 1);
    localparam int SUM_W = OCC_W + PTR_W;

    typedef enum logic {INIT, RUN} state_t;

    state_t                   state;
    logic [SWP_W-1:0]         sweep;
    logic [IDX_W-1:0]         qIdx  [QUEUE_DEPTH];
    logic [DATA_W-1:0]        qData [QUEUE_DEPTH];
    logic [PTR_W-1:0]         rdPtr, wrPtr, rdNext, wrNext;
    logic [OCC_W-1:0]         occ, pushCnt;
    logic [REQ_NUM-1:0]       keep, pushEn;
    logic [REQ_NUM-1:0][PTR_W-1:0] slot;
    logic [7:0]               dropN;
    logic [8:0]               dropSum;
    logic                     ready, accept, pop;

    function automatic logic [PTR_W-1:0] wrapAdd(logic [PTR_W-1:0] base, logic [OCC_W-1:0] off);
        logic [SUM_W-1:0] s;
        s = SUM_W'(base) + SUM_W'(off);
        if (s >= SUM_W'(QUEUE_DEPTH)) s = s - SUM_W'(QUEUE_DEPTH);
        return PTR_W'(s);
    endfunction

    for (genvar g = 0; g < REQ_NUM; g++) begin : gLane
        pht_req_lane #(.LANE(g), .REQ_NUM(REQ_NUM), .IDX_W(IDX_W)) uLane (
            .valid (req.reqValid),
            .idx   (req.reqIdx),
            .keep  (keep[g])
        );
    end

    // No credit for a same-cycle pop: space is judged on registered occupancy.
    assign ready        = (state == RUN) && ((OCC_W'(QUEUE_DEPTH) - occ) >= OCC_W'(REQ_NUM));
    assign req.reqReady = ready;
    assign busy         = (state == INIT);
    assign accept       = ready && !initStart;
    assign pop          = (state == RUN) && (occ != '0) && !initStart;

    // Surviving ports are packed into consecutive FIFO slots in port order.
    always_comb begin
        pushCnt = '0;
        dropN   = '0;
        pushEn  = '0;
        slot    = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            slot[i] = wrapAdd(wrPtr, pushCnt);
            if (accept && keep[i]) begin
                pushEn[i] = 1'b1;
                pushCnt   = pushCnt + OCC_W'(1);
            end
            if (req.reqValid[i] && !accept) dropN = dropN + 8'd1;
        end
        wrNext  = wrapAdd(wrPtr, pushCnt);
        rdNext  = wrapAdd(rdPtr, OCC_W'(1));
        dropSum = {1'b0, dropCount} + {1'b0, dropN};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            sweep     <= '0;
            rdPtr     <= '0;
            wrPtr     <= '0;
            occ       <= '0;
            dropCount <= '0;
            we        <= 1'b0;
            wa        <= '0;
            wv        <= '0;
        end else begin
            dropCount <= dropSum[8] ? 8'hFF : dropSum[7:0];
            if (initStart) begin
                state <= INIT;
                sweep <= '0;
                rdPtr <= '0;
                wrPtr <= '0;
                occ   <= '0;
                we    <= 1'b0;
            end else if (state == INIT) begin
                // Sweep counter runs one past the last index so RUN starts a cycle after the final write.
                if (sweep == SWP_W'(ENTRY_NUM)) begin
                    state <= RUN;
                    we    <= 1'b0;
                end else begin
                    we    <= 1'b1;
                    wa    <= sweep[IDX_W-1:0];
                    wv    <= INIT_VALUE;
                    sweep <= sweep + SWP_W'(1);
                end
            end else begin
                we <= pop;
                if (pop) begin
                    wa    <= qIdx[rdPtr];
                    wv    <= qData[rdPtr];
                    rdPtr <= rdNext;
                end
                wrPtr <= wrNext;
                occ   <= occ + pushCnt - OCC_W'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < REQ_NUM; i++) begin
            if (pushEn[i]) begin
                qIdx[slot[i]]  <= req.reqIdx[i];
                qData[slot[i]] <= req.reqData[i];
            end
        end
    end
endmodule

// File: tb/tb_pht_update_scheduler.sv
// Bench for pht_update_scheduler: scoreboard of expected table writes plus
// a vector table and hand sequences for init, flush, saturation and reset.
module tb_pht_update_scheduler;
    typedef struct {
        logic [9:0] a;
        logic [7:0] v;
    } wr_t;

    typedef struct {
        logic [1:0] vld;
        logic [9:0] i0, i1;
        logic [7:0] d0, d1;
        logic       rdy;
        logic [1:0] acc;
        logic [7:0] dc;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       initStart;
    logic       we;
    logic [9:0] wa;
    logic [7:0] wv;
    logic       busy;
    logic [7:0] dropCount;

    int passCnt = 0;
    int totalCnt = 0;
    wr_t expQ[$];
    vec_t vecs[11];

    pht_update_scheduler_if #(.REQ_NUM(2), .IDX_W(10), .DATA_W(8)) ifc ();

    pht_update_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .initStart (initStart),
        .req       (ifc),
        .we        (we),
        .wa        (wa),
        .wv        (wv),
        .busy      (busy),
        .dropCount (dropCount)
    );

    always #5 clk = ~clk;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic setReq(logic [1:0] v, logic [9:0] i0, logic [7:0] d0, logic [9:0] i1, logic [7:0] d1);
        ifc.reqValid   = v;
        ifc.reqIdx[0]  = i0;
        ifc.reqData[0] = d0;
        ifc.reqIdx[1]  = i1;
        ifc.reqData[1] = d1;
    endtask

    task automatic pushExp(logic [9:0] a, logic [7:0] v);
        wr_t w;
        w.a = a;
        w.v = v;
        expQ.push_back(w);
    endtask

    task automatic pushSweep();
        for (int i = 0; i < 1024; i++) pushExp(10'(i), 8'h22);
    endtask

    // Every table write must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && we === 1'b1) begin
            if (expQ.size() == 0) begin
                check("unexpected_write", {12'h0, wa, 2'b0, wv}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = expQ.pop_front();
                check("write_addr_val", {12'h0, wa, 2'b0, wv}, {12'h0, e.a, 2'b0, e.v});
            end
        end
    end

    task automatic waitWa(string nm, int target);
        bit seen = 1'b0;
        for (int c = 0; c < 1200 && !seen; c++) begin
            @(negedge clk);
            if (we === 1'b1 && wa == 10'(target)) seen = 1'b1;
        end
        check(nm, 32'(seen), 32'd1);
    endtask

    task automatic waitSweepEnd(string nm);
        waitWa({nm, "_last"}, 1023);
        check({nm, "_busy_at_last"}, 32'(busy), 32'd1);
        @(negedge clk);
        check({nm, "_busy_fall"}, 32'(busy), 32'd0);
        check({nm, "_ready_rise"}, 32'(ifc.reqReady), 32'd1);
        check({nm, "_we_idle"}, 32'(we), 32'd0);
    endtask

    initial begin
        int nDrop;
        bit acc;

        // vld, i0, i1, d0, d1, rdy, acc, dc(before this edge)
        vecs[0]  = '{2'b11, 10'd9,  10'd9,  8'd1,  8'd2,  1'b1, 2'b10, 8'd0};
        vecs[1]  = '{2'b00, 10'd0,  10'd0,  8'd0,  8'd0,  1'b1, 2'b00, 8'd0};
        vecs[2]  = '{2'b00, 10'd0,  10'd0,  8'd0,  8'd0,  1'b1, 2'b00, 8'd0};
        vecs[3]  = '{2'b11, 10'd10, 10'd11, 8'd10, 8'd11, 1'b1, 2'b11, 8'd0};
        vecs[4]  = '{2'b11, 10'd12, 10'd13, 8'd12, 8'd13, 1'b1, 2'b11, 8'd0};
        vecs[5]  = '{2'b11, 10'd14, 10'd15, 8'd14, 8'd15, 1'b0, 2'b00, 8'd0};
        vecs[6]  = '{2'b00, 10'd0,  10'd0,  8'd0,  8'd0,  1'b1, 2'b00, 8'd2};
        vecs[7]  = '{2'b00, 10'd0,  10'd0,  8'd0,  8'd0,  1'b1, 2'b00, 8'd2};
        vecs[8]  = '{2'b01, 10'd20, 10'd0,  8'd7,  8'd0,  1'b1, 2'b01, 8'd2};
        vecs[9]  = '{2'b10, 10'd22, 10'd22, 8'd9,  8'd8,  1'b1, 2'b10, 8'd2};
        vecs[10] = '{2'b00, 10'd0,  10'd0,  8'd0,  8'd0,  1'b1, 2'b00, 8'd2};

        rst_n = 1'b0;
        initStart = 1'b0;
        setReq(2'b00, 10'd0, 8'd0, 10'd0, 8'd0);
        repeat (3) @(negedge clk);
        check("rst_we", 32'(we), 32'd0);
        check("rst_wa_wv", {22'h0, wa, wv}, 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_ready", 32'(ifc.reqReady), 32'd0);
        check("rst_drop", 32'(dropCount), 32'd0);

        // Initial sweep after reset release.
        pushSweep();
        rst_n = 1'b1;
        @(negedge clk);
        check("first_sweep_wa0", {22'h0, we, wa}, {22'h0, 1'b1, 10'd0});
        waitSweepEnd("sweep0");

        // Single request: one cycle of latency, then idle.
        setReq(2'b01, 10'd5, 8'd3, 10'd0, 8'd0);
        check("single_ready", 32'(ifc.reqReady), 32'd1);
        pushExp(10'd5, 8'd3);
        @(negedge clk);
        setReq(2'b00, 10'd0, 8'd0, 10'd0, 8'd0);
        check("single_lat_we0", 32'(we), 32'd0);
        @(negedge clk);
        check("single_we1", 32'(we), 32'd1);
        @(negedge clk);
        check("single_we_drop", 32'(we), 32'd0);

        // Vector table: same-index resolution, backpressure, port order.
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            setReq(vecs[k].vld, vecs[k].i0, vecs[k].d0, vecs[k].i1, vecs[k].d1);
            check($sformatf("vec%0d_ready", k), 32'(ifc.reqReady), 32'(vecs[k].rdy));
            check($sformatf("vec%0d_drop", k), 32'(dropCount), 32'(vecs[k].dc));
            if (vecs[k].acc[0]) pushExp(vecs[k].i0, vecs[k].d0);
            if (vecs[k].acc[1]) pushExp(vecs[k].i1, vecs[k].d1);
        end
        repeat (4) @(negedge clk);
        check("vec_drained", 32'(expQ.size()), 32'd0);

        // initStart with three queued: only the already-popped head is written.
        setReq(2'b11, 10'd100, 8'h31, 10'd101, 8'h32);
        check("flush_c1_ready", 32'(ifc.reqReady), 32'd1);
        pushExp(10'd100, 8'h31);
        @(negedge clk);
        setReq(2'b11, 10'd102, 8'h33, 10'd103, 8'h34);
        check("flush_c2_ready", 32'(ifc.reqReady), 32'd1);
        @(negedge clk);
        check("flush_c3_ready", 32'(ifc.reqReady), 32'd0);
        initStart = 1'b1;
        setReq(2'b01, 10'd104, 8'h35, 10'd0, 8'd0);
        #1 pushSweep();
        @(negedge clk);
        initStart = 1'b0;
        setReq(2'b00, 10'd0, 8'd0, 10'd0, 8'd0);
        check("flush_no_write", 32'(we), 32'd0);
        check("flush_busy", 32'(busy), 32'd1);
        check("flush_drop", 32'(dropCount), 32'd3);
        waitSweepEnd("sweep1");

        // Sustained overflow: accept on k=0 and odd k, drop 2 on even k>=2.
        nDrop = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            check("sat_drop", 32'(dropCount), (3 + 2 * nDrop > 255) ? 32'd255 : 32'(3 + 2 * nDrop));
            acc = (k == 0) || (k % 2 == 1);
            setReq(2'b11, 10'(2 * k), 8'(k), 10'(2 * k + 1), 8'(k + 1));
            check("sat_ready", 32'(ifc.reqReady), 32'(acc));
            if (acc) begin
                pushExp(10'(2 * k), 8'(k));
                pushExp(10'(2 * k + 1), 8'(k + 1));
            end else begin
                nDrop++;
            end
        end
        @(negedge clk);
        setReq(2'b00, 10'd0, 8'd0, 10'd0, 8'd0);
        repeat (5) @(negedge clk);
        check("sat_final", 32'(dropCount), 32'd255);
        check("sat_drained", 32'(expQ.size()), 32'd0);

        // initStart from RUN, then again mid-sweep, then reset mid-sweep.
        initStart = 1'b1;
        pushSweep();
        @(negedge clk);
        initStart = 1'b0;
        waitWa("restart_at200", 200);
        #1;
        expQ.delete();
        pushSweep();
        initStart = 1'b1;
        @(negedge clk);
        initStart = 1'b0;
        check("restart_gap", 32'(we), 32'd0);
        @(negedge clk);
        check("restart_wa0", {22'h0, we, wa}, {22'h0, 1'b1, 10'd0});
        waitWa("reset_at500", 500);
        #1 rst_n = 1'b0;
        #1;
        check("async_we", 32'(we), 32'd0);
        check("async_wa_wv", {22'h0, wa, wv}, 32'd0);
        check("async_busy", 32'(busy), 32'd1);
        check("async_ready", 32'(ifc.reqReady), 32'd0);
        check("async_drop", 32'(dropCount), 32'd0);
        expQ.delete();
        pushSweep();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_wa0", {22'h0, we, wa}, {22'h0, 1'b1, 10'd0});
        waitSweepEnd("sweep3");
        check("final_drained", 32'(expQ.size()), 32'd0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
